// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Each slot opens with an all-anodes-off blanking window; code and dp are latched at slot start.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 200
) (
  input  logic       sysclk,
  input  logic       sysreset,
  input  logic [4:0] dig7_i,
  input  logic [4:0] dig6_i,
  input  logic [4:0] dig5_i,
  input  logic [4:0] dig4_i,
  input  logic [4:0] dig3_i,
  input  logic [4:0] dig2_i,
  input  logic [4:0] dig1_i,
  input  logic [4:0] dig0_i,
  input  logic [7:0] dp_i,
  input  logic [7:0] digit_en_i,
  output logic [7:0] an_n_o,
  output logic [6:0] seg_n_o,
  output logic       dp_n_o
);

  localparam int unsigned     CntW     = $clog2(SCAN_DIV);
  localparam logic [CntW-1:0] CntMax   = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      an_n_q, an_n_d;
  logic [6:0]      seg_n_q, seg_n_d;
  logic            dp_n_q, dp_n_d;
  logic [4:0]      code;
  logic [6:0]      lit;

  always_comb begin
    code = 5'h1F;
    case (idx_q)
      3'd0: code = dig0_i;
      3'd1: code = dig1_i;
      3'd2: code = dig2_i;
      3'd3: code = dig3_i;
      3'd4: code = dig4_i;
      3'd5: code = dig5_i;
      3'd6: code = dig6_i;
      3'd7: code = dig7_i;
      default: code = 5'h1F;
    endcase
  end

  // lit is active-high {g,f,e,d,c,b,a}
  always_comb begin
    lit = 7'h00;
    case (code)
      5'h00: lit = 7'h3F;
      5'h01: lit = 7'h06;
      5'h02: lit = 7'h5B;
      5'h03: lit = 7'h4F;
      5'h04: lit = 7'h66;
      5'h05: lit = 7'h6D;
      5'h06: lit = 7'h7D;
      5'h07: lit = 7'h07;
      5'h08: lit = 7'h7F;
      5'h09: lit = 7'h6F;
      5'h0A: lit = 7'h77;
      5'h0B: lit = 7'h7C;
      5'h0C: lit = 7'h39;
      5'h0D: lit = 7'h5E;
      5'h0E: lit = 7'h79;
      5'h0F: lit = 7'h71;
      5'h10: lit = 7'h40;
      5'h11: lit = 7'h38;
      5'h12: lit = 7'h76;
      5'h13: lit = 7'h50;
      5'h14: lit = 7'h5C;
      5'h15: lit = 7'h1C;
      5'h16: lit = 7'h54;
      5'h17: lit = 7'h73;
      5'h18: lit = 7'h01;
      5'h19: lit = 7'h02;
      5'h1A: lit = 7'h04;
      5'h1B: lit = 7'h08;
      5'h1C: lit = 7'h10;
      5'h1D: lit = 7'h20;
      5'h1E: lit = 7'h40;
      default: lit = 7'h00;
    endcase
  end

  always_comb begin
    cnt_d   = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    idx_d   = (cnt_q == CntMax) ? idx_q + 3'd1 : idx_q;
    seg_n_d = seg_n_q;
    dp_n_d  = dp_n_q;
    if (cnt_q == '0) begin
      seg_n_d = ~lit;
      dp_n_d  = ~dp_i[idx_q];
    end
    // Anode follows the next count so it drops in step with the blanking boundary.
    an_n_d = 8'hFF;
    if (cnt_d >= CntBlank) begin
      an_n_d[idx_d] = ~digit_en_i[idx_d];
    end
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      an_n_q  <= 8'hFF;
      seg_n_q <= 7'h7F;
      dp_n_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_n_q  <= an_n_d;
      seg_n_q <= seg_n_d;
      dp_n_q  <= dp_n_d;
    end
  end

  assign an_n_o  = an_n_q;
  assign seg_n_o = seg_n_q;
  assign dp_n_o  = dp_n_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: randomized stimulus against an edge-count reference model
// plus fixed expectations for reset, decode sweep, boot pattern and slot-boundary cases.
module tb_seg7_scan_driver;

  localparam int unsigned SCAN_DIV = 8;
  localparam int unsigned BLANK    = 2;
  localparam int unsigned FRAME    = 8 * SCAN_DIV;

  logic       sysclk = 1'b0;
  logic       sysreset;
  logic [4:0] dig [8];
  logic [7:0] dp;
  logic [7:0] digit_en;
  logic [7:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  int total = 0;
  int bad   = 0;

  seg7_scan_driver #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .sysclk    (sysclk),
    .sysreset  (sysreset),
    .dig7_i    (dig[7]),
    .dig6_i    (dig[6]),
    .dig5_i    (dig[5]),
    .dig4_i    (dig[4]),
    .dig3_i    (dig[3]),
    .dig2_i    (dig[2]),
    .dig1_i    (dig[1]),
    .dig0_i    (dig[0]),
    .dp_i      (dp),
    .digit_en_i(digit_en),
    .an_n_o    (an_n),
    .seg_n_o   (seg_n),
    .dp_n_o    (dp_n)
  );

  always #5 sysclk = ~sysclk;

  // Lit segments per code, spelled as in the decode table.
  string seg_str [32] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg",
                          "aefg", "g", "def", "bcefg", "eg", "cdeg", "cde", "ceg", "abefg",
                          "a", "b", "c", "d", "e", "f", "g", ""};

  function automatic logic [6:0] lit_of(input logic [4:0] code);
    string s;
    lit_of = '0;
    s = seg_str[code];
    for (int i = 0; i < s.len(); i++) lit_of[int'(s[i]) - 97] = 1'b1;
  endfunction

  // Reference model: k = number of clock edges since reset release.
  int unsigned k;
  logic [7:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp;

  function automatic int unsigned slot_of(input int unsigned n);
    return (n / SCAN_DIV) % 8;
  endfunction

  function automatic logic [7:0] an_model(input int unsigned n);
    an_model = 8'hFF;
    if ((n % SCAN_DIV) >= BLANK && digit_en[slot_of(n)]) an_model[slot_of(n)] = 1'b0;
  endfunction

  always @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      k     <= 0;
      m_an  <= 8'hFF;
      m_seg <= 7'h7F;
      m_dp  <= 1'b1;
    end else begin
      if (k % SCAN_DIV == 0) begin
        m_seg <= ~lit_of(dig[slot_of(k)]);
        m_dp  <= ~dp[slot_of(k)];
      end
      m_an <= an_model(k + 1);
      k    <= k + 1;
    end
  end

  // Returns at the negedge where the model state is (slot idx, count c).
  task automatic wait_state(input int unsigned idx, input int unsigned c, input string name);
    bit ok = 0;
    for (int n = 0; n < 3 * FRAME; n++) begin
      @(negedge sysclk);
      if ((k % SCAN_DIV) == c && slot_of(k) == idx) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: timeout waiting for slot %0d cnt %0d", name, idx, c);
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_an;
    sysreset = 1'b1;
    digit_en = 8'hFF;
    dp = 8'h00;
    for (int i = 0; i < 8; i++) dig[i] = 5'($urandom_range(0, 31));
    repeat (3) @(negedge sysclk);
    total++;
    if (an_n !== 8'hFF) begin bad++; $display("FAIL reset_an got=%h exp=ff", an_n); end
    total++;
    if (seg_n !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h exp=7f", seg_n); end
    total++;
    if (dp_n !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b exp=1", dp_n); end
    sysreset = 1'b0;
    for (int e = 1; e <= 72; e++) begin
      @(negedge sysclk);
      if ((e >= 2 && e <= 7) || (e >= 66 && e <= 71)) exp_an = 8'hFE;
      else if (e >= 10 && e <= 15) exp_an = 8'hFD;
      else if (e == 1 || e == 8 || e == 9 || e == 64 || e == 65) exp_an = 8'hFF;
      else exp_an = m_an;
      total++;
      if (an_n !== exp_an) begin
        bad++;
        $display("FAIL release_an edge=%0d got=%h exp=%h", e, an_n, exp_an);
      end
      total++;
      if (seg_n !== m_seg) begin
        bad++;
        $display("FAIL release_seg edge=%0d got=%h exp=%h", e, seg_n, m_seg);
      end
    end
  endtask

  task automatic test_decode_sweep();
    logic [6:0] spot;
    digit_en = 8'h01;
    for (int code = 0; code < 32; code++) begin
      wait_state(7, 3, "sweep_align");
      dig[0] = 5'(code);
      for (int i = 1; i < 8; i++) dig[i] = 5'($urandom_range(0, 31));
      wait_state(0, 4, "sweep_slot0");
      total++;
      if (seg_n !== ~lit_of(5'(code))) begin
        bad++;
        $display("FAIL decode code=%h got=%h exp=%h", code, seg_n, ~lit_of(5'(code)));
      end
      total++;
      if (an_n !== 8'hFE) begin bad++; $display("FAIL sweep_an got=%h exp=fe", an_n); end
      if (code == 8 || code == 16 || code == 30 || code == 31) begin
        spot = (code == 8) ? 7'h00 : (code == 31) ? 7'h7F : 7'h3F;
        total++;
        if (seg_n !== spot) begin
          bad++;
          $display("FAIL decode_spot code=%h got=%h exp=%h", code, seg_n, spot);
        end
      end
    end
  endtask

  task automatic test_boot();
    logic [6:0] boot_exp [8] = '{7'h7F, 7'h40, 7'h19, 7'h12, 7'h06, 7'h46, 7'h06, 7'h7F};
    logic [4:0] boot_dig [8] = '{5'h1F, 5'h00, 5'h04, 5'h05, 5'h0E, 5'h0C, 5'h0E, 5'h1F};
    wait_state(7, 4, "boot_align");
    for (int i = 0; i < 8; i++) dig[i] = boot_dig[i];
    dp = 8'h00;
    digit_en = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      wait_state(i, 4, "boot_slot");
      total++;
      if (seg_n !== boot_exp[i]) begin
        bad++;
        $display("FAIL boot_seg digit=%0d got=%h exp=%h", i, seg_n, boot_exp[i]);
      end
      total++;
      if (dp_n !== 1'b1) begin bad++; $display("FAIL boot_dp digit=%0d got=%b exp=1", i, dp_n); end
      total++;
      if (an_n !== m_an) begin
        bad++;
        $display("FAIL boot_an digit=%0d got=%h exp=%h", i, an_n, m_an);
      end
    end
  endtask

  task automatic test_mid_slot();
    wait_state(3, 4, "mid_align");
    dig[3] = 5'h08;
    for (int c = 4; c < 8; c++) begin
      total++;
      if (seg_n !== 7'h12) begin bad++; $display("FAIL mid_hold cnt=%0d got=%h exp=12", c, seg_n); end
      @(negedge sysclk);
    end
    wait_state(3, 4, "mid_next");
    total++;
    if (seg_n !== 7'h00) begin bad++; $display("FAIL mid_next got=%h exp=00", seg_n); end
  endtask

  task automatic test_enable_dp();
    logic exp_dp;
    wait_state(7, 7, "en_align");
    digit_en = 8'h0F;
    dp = 8'h81;
    for (int i = 0; i < 8; i++) dig[i] = 5'($urandom_range(0, 31));
    for (int n = 0; n < 2 * FRAME; n++) begin
      @(negedge sysclk);
      total++;
      if (an_n[7:4] !== 4'hF) begin bad++; $display("FAIL en_high got=%h exp=fx", an_n); end
      total++;
      if (an_n !== m_an) begin bad++; $display("FAIL en_an got=%h exp=%h", an_n, m_an); end
      if (k % SCAN_DIV == 4) begin
        exp_dp = (slot_of(k) == 0 || slot_of(k) == 7) ? 1'b0 : 1'b1;
        total++;
        if (dp_n !== exp_dp) begin
          bad++;
          $display("FAIL en_dp slot=%0d got=%b exp=%b", slot_of(k), dp_n, exp_dp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3 * FRAME; n++) begin
      if ($urandom_range(0, 3) == 0) dig[$urandom_range(0, 7)] = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 5) == 0) dp = 8'($urandom);
      if ($urandom_range(0, 4) == 0) digit_en = 8'($urandom);
      @(negedge sysclk);
      total++;
      if (an_n !== m_an) begin bad++; $display("FAIL rnd_an got=%h exp=%h", an_n, m_an); end
      total++;
      if (seg_n !== m_seg) begin bad++; $display("FAIL rnd_seg got=%h exp=%h", seg_n, m_seg); end
      total++;
      if (dp_n !== m_dp) begin bad++; $display("FAIL rnd_dp got=%b exp=%b", dp_n, m_dp); end
      total++;
      if ($countones(~an_n) > 1) begin bad++; $display("FAIL rnd_onehot got=%h exp=<=1 low", an_n); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_an;
    digit_en = 8'hFF;
    wait_state(6, 5, "rst_align");
    total++;
    if (an_n !== 8'hBF) begin bad++; $display("FAIL rst_pre got=%h exp=bf", an_n); end
    sysreset = 1'b1;
    #1;
    total++;
    if (an_n !== 8'hFF) begin bad++; $display("FAIL rst_async_an got=%h exp=ff", an_n); end
    total++;
    if (seg_n !== 7'h7F) begin bad++; $display("FAIL rst_async_seg got=%h exp=7f", seg_n); end
    total++;
    if (dp_n !== 1'b1) begin bad++; $display("FAIL rst_async_dp got=%b exp=1", dp_n); end
    repeat (2) @(negedge sysclk);
    sysreset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge sysclk);
      exp_an = (e >= 2 && e <= 7) ? 8'hFE : (e == 10) ? 8'hFD : 8'hFF;
      total++;
      if (an_n !== exp_an) begin
        bad++;
        $display("FAIL rst_resume_an edge=%0d got=%h exp=%h", e, an_n, exp_an);
      end
      if (e <= 8) begin
        total++;
        if (seg_n !== ~lit_of(dig[0])) begin
          bad++;
          $display("FAIL rst_resume_seg edge=%0d got=%h exp=%h", e, seg_n, ~lit_of(dig[0]));
        end
      end
    end
  endtask

  initial begin
    sysreset = 1'b1;
    test_reset();
    test_decode_sweep();
    test_boot();
    test_mid_slot();
    test_enable_dp();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the Nexys4 8-digit seven-segment display. It takes the eight 5-bit digit codes (dig7..dig0) and the eight decimal-point bits written by the PicoBlaze through the bot I/O interface, and scans them onto the shared active-low cathode and anode pins. Each digit slot begins with a blanking window that suppresses ghosting. Digit codes and decimal points are snapshotted once per slot, so a firmware write arriving mid-slot never glitches a lit digit.

## Interface
- SCAN_DIV, 100000: sysclk cycles per digit slot; legal range ≥ 4.
- BLANK_CYCLES, 200: cycles at slot start with all anodes off; legal range 2 ≤ BLANK_CYCLES < SCAN_DIV.

- sysclk  in  1  system clock.
- sysreset  in  1  asynchronous, active-high reset.
- dig7..dig0  in  5 each  digit codes; dig0 is the rightmost digit.
- dp  in  8  decimal points; dp[i]=1 lights the dot of digit i.
- digit_en  in  8  digit_en[i]=0 keeps anode i off for the whole slot.
- an_n  out  8  anodes, active-low; an_n[i] drives digit i.
- seg_n  out  7  cathodes, active-low; {g,f,e,d,c,b,a} = seg_n[6:0].
- dp_n  out  1  decimal-point cathode, active-low.

## Operation
- Prescaler cnt counts 0..SCAN_DIV-1 and wraps. Digit index idx (3 bits) increments when cnt==SCAN_DIV-1 and wraps 7→0.
- When cnt==0: decode dig[idx], register the result into seg_n, and register ~dp[idx] into dp_n. Both hold for the rest of the slot.
- Anodes:
  - an_n = 8'hFF while cnt < BLANK_CYCLES.
  - Otherwise an_n[idx]=~digit_en[idx] and all other anode bits are 1.
  - an_n is registered.
- digit_en is sampled live every cycle; only the digit code and dp are snapshotted.
- Decode table (lit segments):
  - Hex digits 0x00–0x0F:
    - 0: abcdef, 1: bc, 2: abdeg, 3: abcdg
    - 4: bcfg, 5: acdfg, 6: acdefg, 7: abc
    - 8: abcdefg, 9: abcdfg, A: abcefg, b: cdefg
    - C: adef, d: bcdeg, E: adefg, F: aefg
  - 0x10 '-': g. 0x11 'L': def. 0x12 'H': bcefg. 0x13 'r': eg.
  - 0x14 'o': cdeg. 0x15 'u': cde. 0x16 'n': ceg. 0x17 'P': abefg.
  - 0x18..0x1E: the single segment a..g respectively (0x18=a … 0x1E=g), used for the bot-heading indicator.
  - 0x1F: blank, all segments off.

## Timing
- Reset values (asynchronous, while sysreset=1):
  - cnt=0, idx=0.
  - an_n=8'hFF, seg_n=7'h7F, dp_n=1.
- First slot after reset release:
  - The first rising edge after release has cnt=0, idx=0. It loads seg_n/dp_n for digit 0 and advances cnt to 1.
  - an_n[0] goes low on the edge where cnt advances to BLANK_CYCLES, if digit_en[0]=1.
- Latency: digit code to seg_n is one sysclk after the slot-start edge. Segments settle at least BLANK_CYCLES-1 cycles before the anode turns on.
- Slot boundary: on the edge where cnt wraps to 0, an_n returns to 8'hFF on the same edge. seg_n changes on the following edge (cnt==0 → 1). Two adjacent anodes are never low in the same cycle.
- Full frame = 8·SCAN_DIV cycles. Order is digit 0,1,…,7,0.
- Input changes:
  - Code or dp changes mid-slot are ignored until that digit's next slot.
  - A digit_en change takes effect on the next edge.
- Reset asserted mid-slot: all outputs go to reset values immediately (asynchronously). Scanning restarts at digit 0 after release.
- Only one anode may ever be low, at every cycle, including across reset.

## Test plan
- Reset release, SCAN_DIV=8, BLANK_CYCLES=2:
  - During reset: an_n=FF, seg_n=7F, dp_n=1.
  - an_n=FE from the 2nd post-release edge through the 7th.
  - an_n=FD over the corresponding cycles of slot 1.
  - Frame period 64 cycles.
- Decode sweep: set dig0 through all 32 codes (digit_en=01) and check seg_n against the table each frame. Spot checks: 0x08 → seg_n=7'h00; 0x1F → 7'h7F; 0x10 → 7'h3F; 0x1E → 7'h3F.
- Boot pattern: dig7..0 = 1F,0E,0C,0E,05,04,00,1F and dp=0 ("ECE 540"). Per slot, digit 7 → 7F, 6 → 06, 5 → 46, 4 → 06, 3 → 12, 2 → 19, 1 → 40, 0 → 7F; dp_n=1 throughout.
- Mid-slot write: change dig3 from 05 to 08 at cnt=4 of slot 3. seg_n stays 12 until the slot ends and shows 00 in the next frame's slot 3.
- Enable mask and dp: digit_en=0x0F with dp=0x81.
  - Anodes 4–7 are never low.
  - dp_n=0 during slots 0 and 7.
- Reset mid-slot: assert sysreset at cnt=5 of slot 6. an_n=FF on the same cycle, and scanning resumes at digit 0 after release.
